// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access sequencer: req/ack bus, byte lanes, load extension.
// Optional bus timeout is compiled in when DM_TIMEOUT_EN is defined.
module dm_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dm_en,
   input  logic        dm_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic        start, aligned, tmo;
   logic [3:0]  be_n;
   logic [31:0] wd_n, rsh, ext;
   logic [1:0]  lane_q;
   logic [2:0]  f3_q;

   assign start = dm_en & ~flush;
   assign stall = ((state == IDLE) && start) || (state == WAIT);

   // funct3[1:0]: 00 byte, 01 half, anything else is a word access
   always_comb begin
      aligned = 1'b1;
      be_n    = 4'hF;
      wd_n    = wdata;
      case (funct3[1:0])
         2'b00: begin
            be_n = 4'b0001 << addr[1:0];
            wd_n = {4{wdata[7:0]}};
         end
         2'b01: begin
            aligned = ~addr[0];
            be_n    = 4'b0011 << addr[1:0];
            wd_n    = {2{wdata[15:0]}};
         end
         default: aligned = (addr[1:0] == 2'b00);
      endcase
      if (!dm_write) begin
         be_n = 4'hF;
         wd_n = '0;
      end
   end

   always_comb begin
      rsh = mem_rdata >> {lane_q, 3'b000};
      case (f3_q[1:0])
         2'b00:   ext = f3_q[2] ? {24'h0, rsh[7:0]}  : {{24{rsh[7]}}, rsh[7:0]};
         2'b01:   ext = f3_q[2] ? {16'h0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
         default: ext = mem_rdata;
      endcase
   end

`ifdef DM_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tcnt;

   assign tmo = (state == WAIT) && !mem_ack && (tcnt == CW'(TIMEOUT_CYCLES - 1));

   // counter sits at zero outside WAIT, so it is clear on every WAIT entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt    <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= tmo;
         tcnt    <= (state == WAIT) ? tcnt + 1'b1 : '0;
      end
   end
`else
   logic [31:0] unused_tmo;
   assign unused_tmo = TIMEOUT_CYCLES;
   assign tmo        = 1'b0;
   assign bus_err    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ld_data   <= '0;
         misalign  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         lane_q    <= '0;
         f3_q      <= '0;
      end else begin
         misalign <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (aligned) begin
                  mem_req   <= 1'b1;
                  mem_we    <= dm_write;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_be    <= be_n;
                  mem_wdata <= wd_n;
                  lane_q    <= addr[1:0];
                  f3_q      <= funct3;
                  state     <= WAIT;
               end else begin
                  misalign <= 1'b1;
                  ld_data  <= '0;
                  state    <= DONE;
               end
            end
            WAIT: if (mem_ack) begin
               mem_req <= 1'b0;
               if (!mem_we) ld_data <= ext;
               state <= DONE;
            end else if (tmo) begin
               mem_req <= 1'b0;
               ld_data <= '0;
               state   <= DONE;
            end
            // instr still sits in MEM this cycle; returning to IDLE must not re-issue it
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: vector table of accesses plus reset/flush/timeout sequences.
module tb_dm_access_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        dm_en, dm_write, flush, mem_ack;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, mem_rdata;
   logic        stall, misalign, bus_err, mem_req, mem_we;
   logic [31:0] ld_data, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dm_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .dm_en(dm_en), .dm_write(dm_write), .funct3(funct3),
      .addr(addr), .wdata(wdata), .flush(flush), .stall(stall), .ld_data(ld_data),
      .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          dly;
      logic        fl;
      int          nst;
      logic        req;
      logic [31:0] eaddr;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [31:0] eld;
      logic        emis;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // one access: drive at posedge+1, sample 1ns later; ack on WAIT cycle index dly
   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int dly, input logic fl,
                      output int nst, output logic sreq, output logic [31:0] caddr,
                      output logic [3:0] cbe, output logic [31:0] cwd, output logic cwe,
                      output logic [31:0] dld, output logic dmis, output logic derr,
                      output logic unstable, output logic done);
      int wc;
      nst = 0; sreq = 0; caddr = '0; cbe = '0; cwd = '0; cwe = 0;
      dld = '0; dmis = 0; derr = 0; unstable = 0; done = 0; wc = 0;
      @(posedge clk); #1;
      dm_en = 1; dm_write = we; funct3 = f3; addr = a; wdata = wd; flush = 0; mem_ack = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         #1;
         if (stall) nst++;
         if (mem_req) begin
            if (!sreq) begin caddr = mem_addr; cbe = mem_be; cwd = mem_wdata; cwe = mem_we; end
            else if (mem_addr !== caddr || mem_be !== cbe || mem_wdata !== cwd) unstable = 1;
            sreq = 1;
         end
         if (!stall) begin
            done = 1; dld = ld_data; dmis = misalign; derr = bus_err;
            dm_en = 0; flush = 0;
         end else if (mem_req) begin
            mem_ack = (wc == dly); mem_rdata = rd; wc++;
            if (fl) flush = 1;
            @(posedge clk); #1; mem_ack = 0; mem_rdata = 32'hA5A5_5A5A;
         end else begin
            @(posedge clk); #1;
         end
      end
      dm_en = 0; flush = 0;
   endtask

   int          nst;
   logic        sreq, cwe, dmis, derr, unst, done;
   logic [31:0] caddr, cwd, dld;
   logic [3:0]  cbe;

   initial begin
      //        we  f3    addr          wdata         rdata         dly fl nst req  eaddr         be     ewd           eld           mis
      vt[0]  = '{0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 3, 0, 5, 1, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 0};
      vt[1]  = '{0, 3'b000, 32'h103, 32'h0,         32'h80FF0000, 0, 0, 2, 1, 32'h100, 4'hF, 32'h0,        32'hFFFFFF80, 0};
      vt[2]  = '{0, 3'b100, 32'h103, 32'h0,         32'h80FF0000, 0, 0, 2, 1, 32'h100, 4'hF, 32'h0,        32'h00000080, 0};
      vt[3]  = '{1, 3'b001, 32'h202, 32'h1234ABCD,  32'h0,        1, 0, 3, 1, 32'h200, 4'hC, 32'hABCDABCD, 32'h00000080, 0};
      vt[4]  = '{0, 3'b010, 32'h101, 32'h0,         32'h0,        0, 0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h00000000, 1};
      vt[5]  = '{0, 3'b001, 32'h106, 32'h0,         32'h80017FFE, 2, 0, 4, 1, 32'h104, 4'hF, 32'h0,        32'hFFFF8001, 0};
      vt[6]  = '{0, 3'b101, 32'h106, 32'h0,         32'h80017FFE, 0, 0, 2, 1, 32'h104, 4'hF, 32'h0,        32'h00008001, 0};
      vt[7]  = '{1, 3'b000, 32'h301, 32'h000000A5,  32'h0,        0, 1, 2, 1, 32'h300, 4'h2, 32'hA5A5A5A5, 32'h00008001, 0};
      vt[8]  = '{1, 3'b010, 32'h404, 32'hCAFEF00D,  32'h0,        0, 0, 2, 1, 32'h404, 4'hF, 32'hCAFEF00D, 32'h00008001, 0};
      vt[9]  = '{0, 3'b001, 32'h103, 32'h0,         32'h0,        0, 0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h00000000, 1};
      vt[10] = '{0, 3'b110, 32'h010, 32'h0,         32'h12345678, 0, 1, 2, 1, 32'h010, 4'hF, 32'h0,        32'h12345678, 0};
      vt[11] = '{0, 3'b111, 32'h012, 32'h0,         32'h0,        0, 0, 1, 0, 32'h0,   4'h0, 32'h0,        32'h00000000, 1};
      vt[12] = '{0, 3'b100, 32'h101, 32'h0,         32'h0000C300, 0, 0, 2, 1, 32'h100, 4'hF, 32'h0,        32'h000000C3, 0};
      vt[13] = '{0, 3'b000, 32'h102, 32'h0,         32'h007F0000, 1, 0, 3, 1, 32'h100, 4'hF, 32'h0,        32'h0000007F, 0};

      rst_n = 0; dm_en = 0; dm_write = 0; funct3 = 0; addr = 0; wdata = 0;
      flush = 0; mem_ack = 0; mem_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {stall, misalign, bus_err, mem_req, mem_we, mem_be},  '0);
      chk("rst_ld", ld_data, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      @(negedge clk); rst_n = 1;

      for (int i = 0; i < 14; i++) begin
         run(vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, vt[i].rd, vt[i].dly, vt[i].fl,
             nst, sreq, caddr, cbe, cwd, cwe, dld, dmis, derr, unst, done);
         chk($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
         chk($sformatf("v%0d_stall_cycles", i), nst, vt[i].nst);
         chk($sformatf("v%0d_req_seen", i), {31'h0, sreq}, {31'h0, vt[i].req});
         chk($sformatf("v%0d_ld_data", i), dld, vt[i].eld);
         chk($sformatf("v%0d_misalign", i), {31'h0, dmis}, {31'h0, vt[i].emis});
         chk($sformatf("v%0d_bus_err", i), {31'h0, derr}, 32'h0);
         if (vt[i].req) begin
            chk($sformatf("v%0d_mem_addr", i), caddr, vt[i].eaddr);
            chk($sformatf("v%0d_mem_be", i), {28'h0, cbe}, {28'h0, vt[i].ebe});
            chk($sformatf("v%0d_mem_we", i), {31'h0, cwe}, {31'h0, vt[i].we});
            chk($sformatf("v%0d_stable", i), {31'h0, unst}, 32'h0);
            if (vt[i].we) chk($sformatf("v%0d_mem_wdata", i), cwd, vt[i].ewd);
         end
         @(posedge clk); #2;
         chk($sformatf("v%0d_pulse_end", i), {30'h0, misalign, stall}, 32'h0);
      end

      // flush in IDLE blocks the start
      @(posedge clk); #1;
      dm_en = 1; dm_write = 0; funct3 = 3'b010; addr = 32'h500; flush = 1;
      #1; chk("flush_idle_stall", {31'h0, stall}, 32'h0);
      @(posedge clk); #2;
      chk("flush_idle_req", {30'h0, mem_req, stall}, 32'h0);
      @(posedge clk); #2;
      chk("flush_idle_req2", {30'h0, mem_req, misalign}, 32'h0);
      chk("flush_idle_ld", ld_data, 32'h0000007F);
      dm_en = 0; flush = 0;

      // asynchronous reset in the middle of WAIT
      @(posedge clk); #1;
      dm_en = 1; dm_write = 0; funct3 = 3'b010; addr = 32'h600;
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("wait_req", {30'h0, mem_req, stall}, 32'h3);
      rst_n = 0; dm_en = 0;
      #1;
      chk("rst_mid_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mid_stall", {31'h0, stall}, 32'h0);
      chk("rst_mid_ld", ld_data, 32'h0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #2;
      chk("post_rst_idle", {30'h0, mem_req, stall}, 32'h0);

`ifdef DM_TIMEOUT_EN
      run(0, 3'b010, 32'h700, 32'h0, 32'h11111111, 1000, 0,
          nst, sreq, caddr, cbe, cwd, cwe, dld, dmis, derr, unst, done);
      chk("tmo_done", {31'h0, done}, 32'h1);
      chk("tmo_stall_cycles", nst, 5);
      chk("tmo_bus_err", {31'h0, derr}, 32'h1);
      chk("tmo_ld", dld, 32'h0);
      @(posedge clk); #2;
      chk("tmo_pulse_end", {30'h0, bus_err, mem_req}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
